// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_sequencer_if
// Brief   : EXE-stage request/response bundle between pipeline and mul/div unit.
// Revision: 1.0
// ============================================================================
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start_e;
  logic [1:0]       op_e;
  logic [WIDTH-1:0] srca_e;
  logic [WIDTH-1:0] srcb_e;
  logic             mf_req_e;
  logic             mt_e;
  logic             hilo_sel_e;
  logic             flush_e;
  logic             stall_e;
  logic             busy;
  logic [WIDTH-1:0] mf_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             done;
  logic             div0;

  modport master (
    output start_e, op_e, srca_e, srcb_e, mf_req_e, mt_e, hilo_sel_e, flush_e,
    input  stall_e, busy, mf_data, hi, lo, done, div0
  );

  modport slave (
    input  start_e, op_e, srca_e, srcb_e, mf_req_e, mt_e, hilo_sel_e, flush_e,
    output stall_e, busy, mf_data, hi, lo, done, div0
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_sequencer
// Brief   : Bit-serial MULT/MULTU/DIV/DIVU unit owning HI/LO, with EXE stall.
// Revision: 1.0
// ============================================================================
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_is_div;
  logic             r_signed;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [WIDTH-1:0] r_a_raw;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_div0;

  logic             w_s;
  logic             w_m;
  logic             w_r;
  logic             w_busy;
  logic             w_stall;
  logic             w_op_signed;
  logic             w_op_div;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic             w_b_zero;

  assign w_s = bus.start_e  & ~bus.flush_e;
  assign w_m = bus.mt_e     & ~bus.flush_e;
  assign w_r = bus.mf_req_e & ~bus.flush_e;

  assign w_op_signed = ~bus.op_e[0];
  assign w_op_div    =  bus.op_e[1];

  // Signed ops run on magnitudes; the most-negative value still fits unsigned.
  assign w_mag_a = (w_op_signed & bus.srca_e[WIDTH-1]) ? -bus.srca_e : bus.srca_e;
  assign w_mag_b = (w_op_signed & bus.srcb_e[WIDTH-1]) ? -bus.srcb_e : bus.srcb_e;

  // Multiply step: conditional add into the high half, then shift {sum, q} right.
  assign w_sum = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

  // Divide step: bring in the next dividend bit and try subtracting the divisor.
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_diff  = w_shift[WIDTH-1:0] - r_b;

  assign w_b_zero   = (r_b == '0);
  assign w_prod     = {r_rem, r_q};
  assign w_prod_fix = (r_signed & (r_sign_a ^ r_sign_b)) ? -w_prod : w_prod;
  assign w_quo_fix  = (r_signed & (r_sign_a ^ r_sign_b)) ? -r_q    : r_q;
  assign w_rem_fix  = (r_signed & r_sign_a)              ? -r_rem  : r_rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_s) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy      = 1'b0;
      end
    endcase
    w_stall = w_busy & (w_s | w_m | w_r);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_div <= 1'b0;
      r_signed <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_a_raw  <= '0;
      r_b      <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_div0 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_s) begin
            r_is_div <= w_op_div;
            r_signed <= w_op_signed;
            r_sign_a <= w_op_signed & bus.srca_e[WIDTH-1];
            r_sign_b <= w_op_signed & bus.srcb_e[WIDTH-1];
            r_a_raw  <= bus.srca_e;
            r_cnt    <= '0;
            r_rem    <= '0;
            // r_q is the shifting operand: multiplier, or dividend becoming quotient.
            r_q      <= w_op_div ? w_mag_a : w_mag_b;
            r_b      <= w_op_div ? w_mag_b : w_mag_a;
          end else if (w_m) begin
            if (bus.hilo_sel_e) begin
              r_hi <= bus.srca_e;
            end else begin
              r_lo <= bus.srca_e;
            end
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_is_div) begin
            r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], w_ge};
          end else begin
            r_rem <= w_sum[WIDTH:1];
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (r_is_div) begin
            r_div0 <= w_b_zero;
            if (w_b_zero) begin
              r_lo <= '1;
              r_hi <= r_a_raw;
            end else begin
              r_lo <= w_quo_fix;
              r_hi <= w_rem_fix;
            end
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.stall_e = w_stall;
  assign bus.busy    = w_busy;
  assign bus.mf_data = bus.hilo_sel_e ? r_hi : r_lo;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.done    = r_done;
  assign bus.div0    = r_div0;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_muldiv_sequencer
// Brief   : Directed and random EXE traffic checked against a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  muldiv_sequencer_if #(.WIDTH(W)) bus();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: cycles left until the pending result lands, and architectural HI/LO.
  int           m_remain     = 0;
  logic [W-1:0] m_hi         = '0;
  logic [W-1:0] m_lo         = '0;
  logic         m_done       = 1'b0;
  logic         m_div0       = 1'b0;
  logic         m_valid      = 1'b0;
  logic         m_prev_stall = 1'b0;
  logic [2*W:0] p_res        = '0;
  logic         exp_busy;
  logic         exp_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Returns {div0, hi, lo} from plain integer arithmetic.
  function automatic logic [2*W:0] ref_calc(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = 64'(sa * sb); return {1'b0, p}; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      2'b10: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  always @(posedge clk) begin
    m_prev_stall = (m_remain > 0) && (bus.start_e || bus.mt_e || bus.mf_req_e) && !bus.flush_e;
    if (reset) begin
      m_valid  = 1'b1;
      m_remain = 0;
      m_hi     = '0;
      m_lo     = '0;
      m_done   = 1'b0;
      m_div0   = 1'b0;
    end else begin
      m_done = 1'b0;
      m_div0 = 1'b0;
      if (m_remain > 0) begin
        m_remain--;
        if (m_remain == 0) begin
          {m_div0, m_hi, m_lo} = p_res;
          m_done = 1'b1;
        end
      end else if (bus.start_e && !bus.flush_e) begin
        p_res    = ref_calc(bus.op_e, bus.srca_e, bus.srcb_e);
        m_remain = W + 1;
      end else if (bus.mt_e && !bus.flush_e) begin
        if (bus.hilo_sel_e) m_hi = bus.srca_e;
        else                m_lo = bus.srca_e;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      exp_busy  = (m_remain > 0);
      exp_stall = exp_busy && (bus.start_e || bus.mt_e || bus.mf_req_e) && !bus.flush_e;
      chk("busy",    64'(bus.busy),    64'(exp_busy));
      chk("stall_e", 64'(bus.stall_e), 64'(exp_stall));
      chk("done",    64'(bus.done),    64'(m_done));
      chk("div0",    64'(bus.div0),    64'(m_div0));
      chk("hi",      64'(bus.hi),      64'(m_hi));
      chk("lo",      64'(bus.lo),      64'(m_lo));
      chk("mf_data", 64'(bus.mf_data), 64'(bus.hilo_sel_e ? m_hi : m_lo));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.start_e    = 1'b0;
    bus.op_e       = 2'b00;
    bus.srca_e     = '0;
    bus.srcb_e     = '0;
    bus.mf_req_e   = 1'b0;
    bus.mt_e       = 1'b0;
    bus.hilo_sel_e = 1'b0;
    bus.flush_e    = 1'b0;
  endtask

  task automatic wait_release(input string name, output int stalled);
    bit ok;
    ok = 1'b0;
    stalled = 0;
    for (int k = 0; k < 100; k++) begin
      settle();
      if (!bus.stall_e) begin ok = 1'b1; break; end
      stalled++;
    end
    if (!ok) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input logic ediv0);
    int busy_cnt;
    bus.start_e = 1'b1;
    bus.op_e    = op;
    bus.srca_e  = a;
    bus.srcb_e  = b;
    step();
    clear_in();
    busy_cnt = 0;
    for (int k = 1; k <= W + 1; k++) begin
      settle();
      if (bus.busy) busy_cnt++;
    end
    settle();
    chk({name, "_busycycles"}, 64'(busy_cnt), 64'(W + 1));
    chk({name, "_done"}, 64'(bus.done), 64'd1);
    chk({name, "_div0"}, 64'(bus.div0), 64'(ediv0));
    chk({name, "_hi"},   64'(bus.hi),   64'(ehi));
    chk({name, "_lo"},   64'(bus.lo),   64'(elo));
    step();
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      4:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [2*W:0] r;
    int           stalled;
    clear_in();

    r = ref_calc(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("ref_multu", r[63:0], 64'hFFFF_FFFE_0000_0001);
    r = ref_calc(2'b00, 32'hFFFF_FFF9, 32'd3);
    chk("ref_mult", r[63:0], 64'hFFFF_FFFF_FFFF_FFEB);
    r = ref_calc(2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("ref_div", r[63:0], 64'hFFFF_FFFF_FFFF_FFFD);
    r = ref_calc(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ref_divovf", 64'(r), 64'h0000_0000_8000_0000);
    r = ref_calc(2'b11, 32'h1234, 32'd0);
    chk("ref_div0", 64'(r[2*W]), 64'd1);

    step();
    step();
    reset = 1'b0;
    settle();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_hi",   64'(bus.hi),   64'd0);
    chk("rst_lo",   64'(bus.lo),   64'd0);
    step();

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu",      2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("divu_zero", 2'b11, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);

    // MFLO two cycles behind a MULT stalls until the result lands.
    bus.start_e = 1'b1; bus.op_e = 2'b00; bus.srca_e = 32'hFFFF_FFF9; bus.srcb_e = 32'd3;
    step();
    clear_in();
    step();
    bus.mf_req_e = 1'b1; bus.hilo_sel_e = 1'b0;
    wait_release("mflo", stalled);
    chk("mflo_stallcycles", 64'(stalled), 64'(W));
    chk("mflo_done", 64'(bus.done), 64'd1);
    chk("mflo_data", 64'(bus.mf_data), 64'hFFFF_FFEB);
    step();
    clear_in();

    bus.mt_e = 1'b1; bus.hilo_sel_e = 1'b1; bus.srca_e = 32'hA5A5_A5A5;
    step();
    clear_in();
    settle();
    chk("mthi", 64'(bus.hi), 64'hA5A5_A5A5);
    step();

    // MTLO during a divide waits, then overwrites LO after the result.
    bus.start_e = 1'b1; bus.op_e = 2'b11; bus.srca_e = 32'd100; bus.srcb_e = 32'd7;
    step();
    clear_in();
    step();
    bus.mt_e = 1'b1; bus.hilo_sel_e = 1'b0; bus.srca_e = 32'h1234_5678;
    wait_release("mtlo", stalled);
    chk("mtlo_done", 64'(bus.done), 64'd1);
    chk("mtlo_quot", 64'(bus.lo), 64'd14);
    step();
    clear_in();
    settle();
    chk("mtlo_lo", 64'(bus.lo), 64'h1234_5678);
    chk("mtlo_hi", 64'(bus.hi), 64'd2);
    step();

    bus.start_e = 1'b1; bus.flush_e = 1'b1; bus.op_e = 2'b01; bus.srca_e = 32'd5; bus.srcb_e = 32'd6;
    step();
    clear_in();
    settle();
    chk("flush_busy", 64'(bus.busy), 64'd0);
    step();

    // Reset lands while the counter reads 10.
    bus.start_e = 1'b1; bus.op_e = 2'b01; bus.srca_e = 32'd9; bus.srcb_e = 32'd9;
    step();
    clear_in();
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_hi",   64'(bus.hi),   64'd0);
    chk("abort_lo",   64'(bus.lo),   64'd0);
    step();
    run_op("after_abort", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    for (int c = 0; c < 1500; c++) begin
      if (!m_prev_stall) begin
        clear_in();
        bus.srca_e     = rnd_operand();
        bus.srcb_e     = rnd_operand();
        bus.op_e       = 2'($urandom_range(0, 3));
        bus.hilo_sel_e = 1'($urandom_range(0, 1));
        bus.flush_e    = ($urandom_range(0, 9) == 0);
        case ($urandom_range(0, 9))
          0, 1, 2: begin
            bus.start_e = 1'b1;
            bus.mt_e    = ($urandom_range(0, 3) == 0);
          end
          3:       bus.mt_e     = 1'b1;
          4, 5:    bus.mf_req_e = 1'b1;
          default: ;
        endcase
      end
      step();
    end
    clear_in();
    repeat (W + 4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
